// File: rtl/wb_serial_boot_loader_if.sv
// Wishbone write-master bundle used by the serial boot loader.
// The master drives address, data, select and cycle control; the slave returns ack/err.
interface wb_serial_boot_loader_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_serial_boot_loader.sv
// Serial (8N1) firmware loader: writes a received image into RAM over Wishbone, then releases the CPU.
// Defining BOOT_LOADER_CSUM_EN adds a trailing 8-bit checksum byte to the stream.
module wb_serial_boot_loader #(
  parameter int          CLK_DIV        = 434,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [15:0] MAX_WORDS      = 16'h1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    rx_i,
  wb_serial_boot_loader_if.master wb,
  output logic                    cpu_rst_o,
  output logic                    busy_o,
  output logic                    err_o
);

`ifdef BOOT_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int          CW   = (CLK_DIV > 4) ? $clog2(CLK_DIV) : 3;
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_SYNC0, S_SYNC1, S_LEN0, S_LEN1, S_DATA, S_WR, S_CSUM, S_DONE, S_ERR
  } state_t;

  logic          rx_p0, rx_p1, rx_p2;
  logic          rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic          rx_stb;

  state_t        state;
  logic          hold_vld;
  logic [7:0]    hold_byte;
  logic [31:0]   to_cnt;
  logic [15:0]   count;
  logic [15:0]   idx;
  logic [31:0]   waddr;
  logic [31:0]   word;
  logic [1:0]    bcnt;
  logic [7:0]    csum;

  logic          take;
  logic          go_err;
  logic [15:0]   len_w;
  logic [31:0]   word_nxt;

  // Receiver: 2-flop synchroniser, extra flop for falling-edge detect, mid-bit sampling.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      rx_act  <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      rx_stb  <= 1'b0;
    end else begin
      rx_p0  <= rx_i;
      rx_p1  <= rx_p0;
      rx_p2  <= rx_p1;
      rx_stb <= 1'b0;
      if (!rx_act) begin
        if (rx_p2 && !rx_p1) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_p1) rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          if (rx_p1) begin
            rx_stb  <= 1'b1;
            rx_byte <= rx_sh;
          end
        end else begin
          rx_sh <= {rx_p1, rx_sh[7:1]};
        end
      end
    end
  end

  assign take     = hold_vld && (state inside {S_SYNC0, S_SYNC1, S_LEN0, S_LEN1, S_DATA, S_CSUM});
  assign len_w    = {hold_byte, count[7:0]};
  assign word_nxt = {hold_byte, word[31:8]};

  // Bus error, overrun while a write is pending, oversize count or bad checksum all end in S_ERR.
  assign go_err = (state == S_WR && (wb.wbm_err_i || (rx_stb && hold_vld)))
               || (take && state == S_LEN1 && len_w > MAX_WORDS)
               || (take && state == S_CSUM && hold_byte != csum);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SYNC0;
      hold_vld     <= 1'b0;
      hold_byte    <= '0;
      to_cnt       <= '0;
      count        <= '0;
      idx          <= '0;
      waddr        <= BASE_ADDR;
      word         <= '0;
      bcnt         <= '0;
      csum         <= '0;
      wb.wbm_adr_o <= '0;
      wb.wbm_dat_o <= '0;
      wb.wbm_sel_o <= '0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      cpu_rst_o    <= 1'b1;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (rx_stb) begin
        hold_byte <= rx_byte;
        hold_vld  <= 1'b1;
      end else if (take) begin
        hold_vld <= 1'b0;
      end

      if (go_err) begin
        state        <= S_ERR;
        wb.wbm_cyc_o <= 1'b0;
        wb.wbm_stb_o <= 1'b0;
        wb.wbm_we_o  <= 1'b0;
        wb.wbm_sel_o <= '0;
        err_o        <= 1'b1;
        busy_o       <= 1'b0;
      end else begin
        case (state)
          S_SYNC0: begin
            if (rx_stb)                                to_cnt <= '0;
            else if (to_cnt == TIMEOUT_CYCLES - 32'd1) state  <= S_DONE;
            else                                       to_cnt <= to_cnt + 32'd1;
            if (take && hold_byte == 8'h55) begin
              state  <= S_SYNC1;
              busy_o <= 1'b1;
            end
          end
          S_SYNC1: if (take) begin
            if (hold_byte == 8'hAA) begin
              state <= S_LEN0;
              csum  <= '0;
            end else begin
              state  <= S_SYNC0;
              busy_o <= 1'b0;
              to_cnt <= '0;
            end
          end
          S_LEN0: if (take) begin
            count <= {8'h00, hold_byte};
            csum  <= csum + hold_byte;
            state <= S_LEN1;
          end
          S_LEN1: if (take) begin
            count <= len_w;
            csum  <= csum + hold_byte;
            idx   <= '0;
            waddr <= BASE_ADDR;
            bcnt  <= '0;
            if (len_w == 16'd0) begin
              state  <= CSUM_EN ? S_CSUM : S_DONE;
              busy_o <= CSUM_EN;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: if (take) begin
            word <= word_nxt;
            csum <= csum + hold_byte;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state        <= S_WR;
              wb.wbm_cyc_o <= 1'b1;
              wb.wbm_stb_o <= 1'b1;
              wb.wbm_we_o  <= 1'b1;
              wb.wbm_sel_o <= 4'hF;
              wb.wbm_adr_o <= waddr;
              wb.wbm_dat_o <= word_nxt;
            end
          end
          S_WR: if (wb.wbm_ack_i) begin
            wb.wbm_cyc_o <= 1'b0;
            wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0;
            wb.wbm_sel_o <= '0;
            idx          <= idx + 16'd1;
            waddr        <= waddr + 32'd4;
            if (idx + 16'd1 == count) begin
              state  <= CSUM_EN ? S_CSUM : S_DONE;
              busy_o <= CSUM_EN;
            end else begin
              state <= S_DATA;
            end
          end
          S_CSUM: if (take) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
          end
          S_DONE: begin
            cpu_rst_o <= 1'b0;
            busy_o    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_serial_boot_loader.sv
// Scoreboard bench for wb_serial_boot_loader: serial stimulus in, Wishbone writes checked by a monitor.
module tb_wb_serial_boot_loader;
  localparam int          CLK_DIV = 8;
  localparam logic [31:0] BASE    = 32'h100;
  localparam logic [31:0] TMO     = 32'd2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic cpu_rst, busy, err;

  wb_serial_boot_loader_if wb();

  wb_serial_boot_loader #(
    .CLK_DIV(CLK_DIV), .BASE_ADDR(BASE), .MAX_WORDS(16'h1000), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .rx_i(rx), .wb(wb),
    .cpu_rst_o(cpu_rst), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int wr_cnt = 0;
  int last_ack_cyc = -1;
  int rel_cyc = -1;
  int ack_delay = 0;
  int slv_wait = 0;
  bit inject_err = 0;
  bit pace = 0;
  logic prev_rst = 1'b1;
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [31:0] wq[$];

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: ack (or injected err) after ack_delay cycles of a pending strobe.
  initial begin
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (wb.wbm_ack_i || wb.wbm_err_i) begin
        wb.wbm_ack_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        slv_wait = 0;
      end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
        if (slv_wait >= ack_delay) begin
          if (inject_err) begin
            wb.wbm_err_i = 1'b1;
            inject_err = 0;
          end else begin
            wb.wbm_ack_i = 1'b1;
          end
        end else begin
          slv_wait++;
        end
      end else begin
        slv_wait = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every terminated bus cycle and timestamps the CPU release.
  initial begin
    logic [31:0] ea, ed;
    forever begin
      @(negedge clk); #3;
      if (wb.wbm_cyc_o && wb.wbm_stb_o && (wb.wbm_ack_i || wb.wbm_err_i)) begin
        wr_cnt++;
        last_ack_cyc = cyc_no;
        total++;
        if (exp_adr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got adr=%h dat=%h want no write", wb.wbm_adr_o, wb.wbm_dat_o);
        end else begin
          ea = exp_adr.pop_front();
          ed = exp_dat.pop_front();
          if (wb.wbm_adr_o !== ea || wb.wbm_dat_o !== ed || wb.wbm_sel_o !== 4'hF || wb.wbm_we_o !== 1'b1) begin
            bad++;
            $display("FAIL write: got adr=%h dat=%h sel=%h we=%b want adr=%h dat=%h sel=f we=1",
                     wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o, wb.wbm_we_o, ea, ed);
          end
        end
      end
      if (prev_rst && !cpu_rst && rst_n) rel_cyc = cyc_no;
      prev_rst = cpu_rst;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_adr.push_back(a);
    exp_dat.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    ack_delay = 0;
    inject_err = 0;
    pace = 0;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_bus", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o, wb.wbm_adr_o, wb.wbm_dat_o}, 0);
    check("rst_flags", {busy, err}, 0);
    rst_n = 1'b1;
    wr_cnt = 0;
    rel_cyc = -1;
    last_ack_cyc = -1;
    exp_adr.delete();
    exp_dat.delete();
    wq.delete();
  endtask

  task automatic end_test(input string name);
    check({name, "_scoreboard_empty"}, exp_adr.size(), 0);
    exp_adr.delete();
    exp_dat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (stop ? CLK_DIV / 2 : 2 * CLK_DIV) @(negedge clk);
    if (pace) begin
      for (int k = 0; k < 2000 && wb.wbm_cyc_o; k++) @(negedge clk);
      if (wb.wbm_cyc_o) begin
        total++;
        bad++;
        $display("FAIL pace_wait: got cyc=1 want cyc=0 within 2000 cycles");
      end
    end
  endtask

  task automatic send_load(input logic [15:0] n, input bit chk_busy);
    logic [7:0]  s;
    logic [31:0] w;
    s = n[7:0] + n[15:8];
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    if (chk_busy) check("busy_during_load", busy, 1);
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b1);
      send_byte(w[23:16], 1'b1);
      send_byte(w[31:24], 1'b1);
    end
`ifdef BOOT_LOADER_CSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && cpu_rst && !err; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Timeout with an idle line.
    do_reset();
    repeat (1995) @(negedge clk);
    check("t1_before_timeout", cpu_rst, 1);
    repeat (8) @(negedge clk);
    check("t1_released", cpu_rst, 0);
    check("t1_no_writes", wr_cnt, 0);
    check("t1_flags", {busy, err}, 0);
    end_test("t1");

    // Two-word image, immediate ack.
    do_reset();
    wq = '{32'h12345678, 32'hDEADBEEF};
    expect_wr(32'h100, 32'h12345678);
    expect_wr(32'h104, 32'hDEADBEEF);
    send_load(16'd2, 1'b1);
    wait_done(500);
    check("t2_release", cpu_rst, 0);
    check("t2_err", err, 0);
    check("t2_busy", busy, 0);
    check("t2_writes", wr_cnt, 2);
    check("t2_release_latency", rel_cyc - last_ack_cyc, 2);
    end_test("t2");

    // Slow slave, host paced by the bus.
    do_reset();
    ack_delay = 300;
    pace = 1;
    wq = '{32'h12345678, 32'hDEADBEEF};
    expect_wr(32'h100, 32'h12345678);
    expect_wr(32'h104, 32'hDEADBEEF);
    send_load(16'd2, 1'b0);
    pace = 0;
    wait_done(2000);
    check("t3_release", cpu_rst, 0);
    check("t3_err", err, 0);
    check("t3_writes", wr_cnt, 2);
    end_test("t3");

    // Bus error on the first write.
    do_reset();
    inject_err = 1;
    wq = '{32'h12345678, 32'hDEADBEEF};
    expect_wr(32'h100, 32'h12345678);
    send_load(16'd2, 1'b0);
    wait_done(500);
    repeat (50) @(negedge clk);
    check("t4_err", err, 1);
    check("t4_cpu_rst", cpu_rst, 1);
    check("t4_busy", busy, 0);
    check("t4_writes", wr_cnt, 1);
    check("t4_bus_idle", wb.wbm_cyc_o, 0);
    end_test("t4");

    // Unpaced host against a slow slave overruns the holding register.
    do_reset();
    ack_delay = 300;
    wq = '{32'h12345678, 32'hDEADBEEF};
    send_load(16'd2, 1'b0);
    wait_done(500);
    check("ovr_err", err, 1);
    check("ovr_cpu_rst", cpu_rst, 1);
    check("ovr_writes", wr_cnt, 0);
    check("ovr_bus_idle", wb.wbm_cyc_o, 0);
    end_test("ovr");

    // Framing error on a sync byte, then a one-word image.
    do_reset();
    send_byte(8'h55, 1'b0);
    wq = '{32'hCAFEF00D};
    expect_wr(32'h100, 32'hCAFEF00D);
    send_load(16'd1, 1'b0);
    wait_done(500);
    check("t5_release", cpu_rst, 0);
    check("t5_writes", wr_cnt, 1);
    check("t5_err", err, 0);
    end_test("t5");

    // Zero-length image boots straight away.
    do_reset();
    send_load(16'd0, 1'b0);
    wait_done(500);
    check("zero_release", cpu_rst, 0);
    check("zero_writes", wr_cnt, 0);
    check("zero_err", err, 0);
    end_test("zero");

    // Count one above the limit.
    do_reset();
    send_load(16'h1001, 1'b0);
    wait_done(500);
    check("big_err", err, 1);
    check("big_cpu_rst", cpu_rst, 1);
    check("big_writes", wr_cnt, 0);
    end_test("big");

`ifdef BOOT_LOADER_CSUM_EN
    do_reset();
    expect_wr(32'h100, 32'h04030201);
    foreach (wq[i]) wq[i] = 0;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0B, 1'b1);
    wait_done(500);
    check("csum_ok_release", cpu_rst, 0);
    check("csum_ok_err", err, 0);
    end_test("csum_ok");

    do_reset();
    expect_wr(32'h100, 32'h04030201);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0C, 1'b1);
    wait_done(500);
    check("csum_bad_err", err, 1);
    check("csum_bad_cpu_rst", cpu_rst, 1);
    end_test("csum_bad");
`endif

    // Asynchronous reset while a write is outstanding.
    do_reset();
    ack_delay = 300;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    for (int k = 0; k < 200 && !wb.wbm_cyc_o; k++) @(negedge clk);
    check("abort_cycle_open", wb.wbm_cyc_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cyc", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    end_test("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
